// File: rtl/cpu_debug_ocimem_engine.sv
// JTAG OCI memory engine: debug commands to single-word Avalon-MM accesses.
// Optional stall timeout: define CPU_DEBUG_OCIMEM_TIMEOUT_EN.
module cpu_debug_ocimem_engine #(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic              any_strobe;
    logic              multi_strobe;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              err_set;
    logic              err_clr;
    logic              unused_jdo;

    assign m_address    = addr;
    assign m_byteenable = 4'hF;
    assign unused_jdo   = ^jdo[37:36];

    always_comb begin
        any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a |
                       take_action_ocimem_b;
        multi_strobe = (take_action_ocimem_a & take_no_action_ocimem_a) |
                       (take_action_ocimem_a & take_action_ocimem_b) |
                       (take_no_action_ocimem_a & take_action_ocimem_b);
        busy         = (state == ST_RD) | (state == ST_WR);
        done         = busy & ~m_waitrequest;
    end

`ifdef CPU_DEBUG_OCIMEM_TIMEOUT_EN
    localparam int TO_LOG = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W   = (TO_LOG < 8) ? 8 : TO_LOG;

    logic [TO_W-1:0] to_cnt;

    // Counter is zero whenever idle, so every new access starts fresh
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (!busy) begin
            to_cnt <= '0;
        end else if (m_waitrequest) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout = busy & m_waitrequest &
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Set beats clear when a clearing command also loses arbitration
    always_comb begin
        err_set = timeout | (busy ? any_strobe : multi_strobe);
        err_clr = (state == ST_IDLE) & take_action_ocimem_a & jdo[35];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            monitor_error <= 1'b0;
        end else if (err_set) begin
            monitor_error <= 1'b1;
        end else if (err_clr) begin
            monitor_error <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr          <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            m_read        <= 1'b0;
            m_write       <= 1'b0;
            m_writedata   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (take_action_ocimem_a) begin
                        addr <= jdo[ADDR_W+1:2];
                        if (jdo[34]) begin
                            state         <= ST_RD;
                            m_read        <= 1'b1;
                            monitor_ready <= 1'b0;
                        end
                    end else if (take_action_ocimem_b) begin
                        m_writedata   <= jdo[31:0];
                        state         <= ST_WR;
                        m_write       <= 1'b1;
                        monitor_ready <= 1'b0;
                    end else if (take_no_action_ocimem_a) begin
                        state         <= ST_RD;
                        m_read        <= 1'b1;
                        monitor_ready <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (timeout) begin
                        MonDReg       <= 32'hDEADBEEF;
                        state         <= ST_IDLE;
                        m_read        <= 1'b0;
                        monitor_ready <= 1'b1;
                    end else if (done) begin
                        MonDReg       <= m_readdata;
                        addr          <= addr + ADDR_W'(1);
                        state         <= ST_IDLE;
                        m_read        <= 1'b0;
                        monitor_ready <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (timeout) begin
                        state         <= ST_IDLE;
                        m_write       <= 1'b0;
                        monitor_ready <= 1'b1;
                    end else if (done) begin
                        addr          <= addr + ADDR_W'(1);
                        state         <= ST_IDLE;
                        m_write       <= 1'b0;
                        monitor_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    m_read        <= 1'b0;
                    m_write       <= 1'b0;
                    monitor_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_debug_ocimem_engine.sv
// Bench for cpu_debug_ocimem_engine: directed table, corner sequences, random vs model.
// Timeout section follows CPU_DEBUG_OCIMEM_TIMEOUT_EN.
module tb_cpu_debug_ocimem_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [9:0]  m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic [31:0] m_readdata = '0;
    logic        m_waitrequest = 1'b0;

    cpu_debug_ocimem_engine #(.ADDR_W(10), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready),
        .monitor_error(monitor_error), .m_address(m_address),
        .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_readdata(m_readdata),
        .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Slave memory (what the DUT sees) and independent model memory
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    typedef struct packed {
        logic       wr;
        logic [9:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t acc_q[$];

    int   stall_fixed = 0;
    int   stall_target = 0;
    int   stall_cnt = 0;
    bit   in_acc = 0;
    bit   hold = 0;
    logic [43:0] hsig;

    always @(negedge clk) begin
        if (hold && (m_read || m_write))
            chk("hold_stable", {m_read, m_write, m_address, m_writedata}, hsig);
        if (m_read || m_write) begin
            if (!in_acc) begin
                in_acc = 1;
                stall_cnt = 0;
                stall_target = (stall_fixed < 0) ? $urandom_range(0, 3) : stall_fixed;
            end
            m_waitrequest = (stall_cnt < stall_target);
            if (m_waitrequest) stall_cnt++;
        end else begin
            in_acc = 0;
            m_waitrequest = 1'($urandom_range(0, 1));
        end
        m_readdata = m_read ? mem[m_address] : $urandom;
        hold = (m_read || m_write) && m_waitrequest;
        hsig = {m_read, m_write, m_address, m_writedata};
    end

    always @(posedge clk) begin
        if (!reset && !m_waitrequest && (m_read || m_write)) begin
            acc_q.push_back({m_write, m_address, m_write ? m_writedata : m_readdata});
            if (m_write) mem[m_address] = m_writedata;
        end
    end

    // Transaction-level reference model
    logic [9:0]  md_addr = '0;
    bit          md_err  = 0;
    logic [31:0] md_mon  = '0;

    task automatic model_cmd(input bit a, input bit na, input bit b,
                             input logic [37:0] j, output bit acc,
                             output bit wr, output logic [9:0] aa,
                             output logic [31:0] dd);
        int n;
        n = int'(a) + int'(na) + int'(b);
        acc = 0; wr = 0; aa = '0; dd = '0;
        if (a) begin
            md_addr = j[11:2];
            if (j[35]) md_err = 0;
            acc = j[34];
        end else if (b) begin
            acc = 1; wr = 1; dd = j[31:0];
        end else if (na) begin
            acc = 1;
        end
        if (n > 1) md_err = 1;
        if (acc) begin
            aa = md_addr;
            if (wr) ref_mem[aa] = dd;
            else begin dd = ref_mem[aa]; md_mon = dd; end
            md_addr = md_addr + 10'd1;
        end
    endtask

    task automatic do_cmd(input bit a, input bit na, input bit b,
                          input logic [37:0] j, output int busy);
        @(negedge clk);
        take_action_ocimem_a = a;
        take_no_action_ocimem_a = na;
        take_action_ocimem_b = b;
        jdo = j;
        @(negedge clk);
        take_action_ocimem_a = 0;
        take_no_action_ocimem_a = 0;
        take_action_ocimem_b = 0;
        busy = 0;
        for (int k = 0; k < 2000 && (m_read || m_write); k++) begin
            busy++;
            @(negedge clk);
        end
        if (m_read || m_write) chk("cmd_bound", 1, 0);
    endtask

    task automatic check_after(input string nm, input bit acc, input bit wr,
                               input logic [9:0] aa, input logic [31:0] dd,
                               input logic [9:0] ea, input bit ee,
                               input logic [31:0] em);
        acc_t r;
        if (acc) begin
            chk({nm, "_acc_n"}, acc_q.size(), 1);
            if (acc_q.size() > 0) begin
                r = acc_q.pop_front();
                chk({nm, "_acc"}, r, {wr, aa, dd});
            end
        end else begin
            chk({nm, "_noacc"}, acc_q.size(), 0);
        end
        acc_q.delete();
        chk({nm, "_addr"}, m_address, ea);
        chk({nm, "_err"}, monitor_error, ee);
        chk({nm, "_mon"}, MonDReg, em);
        chk({nm, "_ready"}, monitor_ready, 1);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_rd_wr"}, {m_read, m_write}, 0);
        chk({nm, "_ready"}, monitor_ready, 1);
        chk({nm, "_err"}, monitor_error, 0);
        chk({nm, "_mon"}, MonDReg, 0);
        chk({nm, "_addr"}, m_address, 0);
        chk({nm, "_wdata"}, m_writedata, 0);
        chk({nm, "_be"}, m_byteenable, 4'hF);
        chk({nm, "_noacc"}, acc_q.size(), 0);
        acc_q.delete();
        reset = 0;
        md_addr = '0; md_err = 0; md_mon = '0;
    endtask

    typedef struct {
        string       nm;
        bit          a, na, b;
        logic [37:0] j;
        int          stall;
        bit          acc, wr;
        logic [9:0]  aa;
        logic [31:0] dd;
        int          busy;
        logic [9:0]  after;
        bit          err;
        logic [31:0] mon;
    } vec_t;

    function automatic vec_t mk(string nm, bit a, bit na, bit b,
                                logic [37:0] j, int st, bit acc, bit wr,
                                logic [9:0] aa, logic [31:0] dd, int busy,
                                logic [9:0] after, bit err, logic [31:0] mon);
        vec_t v;
        v.nm = nm; v.a = a; v.na = na; v.b = b; v.j = j; v.stall = st;
        v.acc = acc; v.wr = wr; v.aa = aa; v.dd = dd; v.busy = busy;
        v.after = after; v.err = err; v.mon = mon;
        return v;
    endfunction

    initial begin
        vec_t tbl[13];
        int   busy;
        bit   acc, wr;
        logic [9:0]  aa;
        logic [31:0] dd;
        logic [37:0] j;
        bit   a, na, b;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h5A000000 | i;
            ref_mem[i] = mem[i];
        end
        mem[16] = 32'h12345678;
        ref_mem[16] = 32'h12345678;

        tbl[0]  = mk("rd010", 1,0,0, 38'h4_0000_0040, 0, 1,0, 10'h010, 32'h12345678, 1, 10'h011, 0, 32'h12345678);
        tbl[1]  = mk("wrA",   0,0,1, 38'h0_0000_000A, 3, 1,1, 10'h011, 32'hA, 4, 10'h012, 0, 32'h12345678);
        tbl[2]  = mk("wrB",   0,0,1, 38'h0_0000_000B, 3, 1,1, 10'h012, 32'hB, 4, 10'h013, 0, 32'h12345678);
        tbl[3]  = mk("wrC",   0,0,1, 38'h0_0000_000C, 3, 1,1, 10'h013, 32'hC, 4, 10'h014, 0, 32'h12345678);
        tbl[4]  = mk("set3ff",1,0,0, 38'h0_0000_0FFC, 0, 0,0, 10'h000, 32'h0, 0, 10'h3FF, 0, 32'h12345678);
        tbl[5]  = mk("rd3ff", 0,1,0, 38'h0,           0, 1,0, 10'h3FF, 32'h5A0003FF, 1, 10'h000, 0, 32'h5A0003FF);
        tbl[6]  = mk("rd000", 0,1,0, 38'h0,           1, 1,0, 10'h000, 32'h5A000000, 2, 10'h001, 0, 32'h5A000000);
        tbl[7]  = mk("a_b",   1,0,1, 38'h0_0000_0080, 0, 0,0, 10'h000, 32'h0, 0, 10'h020, 1, 32'h5A000000);
        tbl[8]  = mk("clr",   1,0,0, 38'h8_0000_00C0, 0, 0,0, 10'h000, 32'h0, 0, 10'h030, 0, 32'h5A000000);
        tbl[9]  = mk("clr_lose",1,1,0,38'h8_0000_0100, 0, 0,0, 10'h000, 32'h0, 0, 10'h040, 1, 32'h5A000000);
        tbl[10] = mk("clr2",  1,0,0, 38'h8_0000_0100, 0, 0,0, 10'h000, 32'h0, 0, 10'h040, 0, 32'h5A000000);
        tbl[11] = mk("all3",  1,1,1, 38'h4_0000_0140, 0, 1,0, 10'h050, 32'h5A000050, 1, 10'h051, 1, 32'h5A000050);
        tbl[12] = mk("clr0",  1,0,0, 38'h8_0000_0000, 0, 0,0, 10'h000, 32'h0, 0, 10'h000, 0, 32'h5A000050);

        do_reset("reset");

        foreach (tbl[i]) begin
            stall_fixed = tbl[i].stall;
            do_cmd(tbl[i].a, tbl[i].na, tbl[i].b, tbl[i].j, busy);
            model_cmd(tbl[i].a, tbl[i].na, tbl[i].b, tbl[i].j, acc, wr, aa, dd);
            if (tbl[i].acc) chk({tbl[i].nm, "_busy"}, busy, tbl[i].busy);
            check_after(tbl[i].nm, tbl[i].acc, tbl[i].wr, tbl[i].aa, tbl[i].dd,
                        tbl[i].after, tbl[i].err, tbl[i].mon);
        end

        // Strobe arriving while a read is stalled
        stall_fixed = 4;
        @(negedge clk);
        take_no_action_ocimem_a = 1;
        @(negedge clk);
        take_no_action_ocimem_a = 0;
        chk("busy_rd_high", m_read, 1);
        @(negedge clk);
        take_action_ocimem_b = 1;
        jdo = 38'h0_0000_FFFF;
        @(negedge clk);
        take_action_ocimem_b = 0;
        chk("busy_err", monitor_error, 1);
        for (int k = 0; k < 50 && (m_read || m_write); k++) @(negedge clk);
        model_cmd(0, 1, 0, 38'h0, acc, wr, aa, dd);
        md_err = 1;
        check_after("busy_strobe", acc, wr, aa, dd, md_addr, md_err, md_mon);

        stall_fixed = 0;
        do_cmd(1, 0, 0, 38'h8_0000_0400, busy);
        model_cmd(1, 0, 0, 38'h8_0000_0400, acc, wr, aa, dd);
        check_after("clr100", acc, wr, aa, dd, md_addr, md_err, md_mon);

        stall_fixed = 100000;
`ifdef CPU_DEBUG_OCIMEM_TIMEOUT_EN
        do_cmd(0, 1, 0, 38'h0, busy);
        chk("to_busy", busy, 255);
        md_mon = 32'hDEADBEEF;
        md_err = 1;
        check_after("timeout", 0, 0, 10'h0, 32'h0, 10'h100, 1, 32'hDEADBEEF);
`else
        @(negedge clk);
        take_no_action_ocimem_a = 1;
        @(negedge clk);
        take_no_action_ocimem_a = 0;
        repeat (1000) @(negedge clk);
        chk("stuck_rd", m_read, 1);
        chk("stuck_addr", m_address, 10'h100);
        chk("stuck_ready", monitor_ready, 0);
`endif

        if (!m_read) begin
            @(negedge clk);
            take_no_action_ocimem_a = 1;
            @(negedge clk);
            take_no_action_ocimem_a = 0;
            chk("pre_rst_rd", m_read, 1);
        end
        do_reset("mid_rst");

        stall_fixed = -1;
        for (int t = 0; t < 200; t++) begin
            int r;
            r = $urandom_range(0, 9);
            a  = (r < 3);
            na = (r >= 3 && r < 6);
            b  = (r >= 6 && r < 9);
            if (r == 9) begin
                a  = 1'($urandom_range(0, 1));
                na = 1'($urandom_range(0, 1));
                b  = 1'($urandom_range(0, 1));
            end
            j = {6'($urandom), 32'($urandom)};
            do_cmd(a, na, b, j, busy);
            model_cmd(a, na, b, j, acc, wr, aa, dd);
            check_after($sformatf("rnd%0d", t), acc, wr, aa, dd,
                        md_addr, md_err, md_mon);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
